// File: rtl/t03_mmio_pkg.sv
// t03_mmio_pkg: shared addresses, writer states and display-word packing for the game-state MMIO link
package t03_mmio_pkg;
   localparam logic [31:0] STATUS_ADDR = 32'hFF00_0004;
   localparam logic [31:0] POS_ADDR = 32'hFF00_0008;
   typedef enum logic [1:0] {IDLE, STATUS, POS} wstate_t;
   function automatic logic [31:0] pack_status(
      input logic [2:0] game_state,
      input logic [1:0] p1_state,
      input logic [1:0] p2_state,
      input logic [3:0] p1_health,
      input logic [3:0] p2_health,
      input logic p1_left,
      input logic p2_left
   );
      return {1'b0, game_state, p1_state, p2_state, p1_health, p2_health, 14'b0, p1_left, p2_left};
   endfunction
   function automatic logic [31:0] pack_pos(
      input logic [7:0] x1,
      input logic [7:0] y1,
      input logic [7:0] x2,
      input logic [7:0] y2
   );
      return {x1, y1, x2, y2};
   endfunction
endpackage

// File: rtl/mmio_state_writer.sv
// mmio_state_writer: snapshots game state and writes changed display words over the MMIO bus
module mmio_state_writer #(
   parameter logic [31:0] STATUS_ADDR = t03_mmio_pkg::STATUS_ADDR,
   parameter logic [31:0] POS_ADDR = t03_mmio_pkg::POS_ADDR,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input logic clk,
   input logic rst,
   input logic update,
   input logic [2:0] gameState,
   input logic [1:0] p1State,
   input logic [1:0] p2State,
   input logic [3:0] p1health,
   input logic [3:0] p2health,
   input logic [7:0] x1,
   input logic [7:0] y1,
   input logic [7:0] x2,
   input logic [7:0] y2,
   input logic p1Left,
   input logic p2Left,
   input logic ack,
   output logic [31:0] addr,
   output logic [31:0] data,
   output logic wen,
   output logic busy,
   output logic err
);
   import t03_mmio_pkg::wstate_t;
   import t03_mmio_pkg::IDLE;
   import t03_mmio_pkg::STATUS;
   import t03_mmio_pkg::POS;
   import t03_mmio_pkg::pack_status;
   import t03_mmio_pkg::pack_pos;
   wstate_t state_q, state_d;
   logic [31:0] stat_sh_q, stat_sh_d, pos_sh_q, pos_sh_d;
   logic [31:0] stat_last_q, stat_last_d, pos_last_q, pos_last_d;
   logic [31:0] cnt_q, cnt_d;
   logic pending_q, pending_d, first_q, first_d, err_q, err_d;
   logic wen_q, busy_q;
   logic exit_chk, snap;
   // next-state: ack/timeout handling, pending coalescing, and the snapshot decision shared by IDLE and the exit check
   always_comb begin
      state_d = state_q;
      stat_sh_d = stat_sh_q;
      pos_sh_d = pos_sh_q;
      stat_last_d = stat_last_q;
      pos_last_d = pos_last_q;
      pending_d = pending_q;
      first_d = first_q;
      err_d = err_q;
      cnt_d = cnt_q;
      exit_chk = 1'b0;
      snap = 1'b0;
      if (state_q == IDLE) begin
         snap = update;
      end else begin
         pending_d = pending_q | update;
         cnt_d = cnt_q + 32'd1;
         if (ack) begin
            cnt_d = '0;
            if (state_q == STATUS) begin
               stat_last_d = stat_sh_q;
               if (pos_sh_q != pos_last_q || first_q) state_d = POS;
               else exit_chk = 1'b1;
            end else begin
               pos_last_d = pos_sh_q;
               first_d = 1'b0;
               exit_chk = 1'b1;
            end
         end else if (ACK_TIMEOUT != 0 && cnt_d == ACK_TIMEOUT) begin
            err_d = 1'b1;
            cnt_d = '0;
            exit_chk = 1'b1;
         end
         if (exit_chk) begin
            state_d = IDLE;
            snap = pending_d;
            pending_d = 1'b0;
         end
      end
      if (snap) begin
         stat_sh_d = pack_status(gameState, p1State, p2State, p1health, p2health, p1Left, p2Left);
         pos_sh_d = pack_pos(x1, y1, x2, y2);
         cnt_d = '0;
         state_d = (stat_sh_d != stat_last_d || first_d) ? STATUS :
                   (pos_sh_d != pos_last_d) ? POS : IDLE;
      end
   end
   // state, shadows, last-written words and registered bus-request outputs; reset aborts any write at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stat_sh_q <= '0;
         pos_sh_q <= '0;
         stat_last_q <= '0;
         pos_last_q <= '0;
         cnt_q <= '0;
         pending_q <= 1'b0;
         first_q <= 1'b1;
         err_q <= 1'b0;
         wen_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stat_sh_q <= stat_sh_d;
         pos_sh_q <= pos_sh_d;
         stat_last_q <= stat_last_d;
         pos_last_q <= pos_last_d;
         cnt_q <= cnt_d;
         pending_q <= pending_d;
         first_q <= first_d;
         err_q <= err_d;
         wen_q <= state_d != IDLE;
         busy_q <= state_d != IDLE;
      end
   end
   // bus address/data decoded from registered state and shadows only
   always_comb begin
      addr = state_q == STATUS ? STATUS_ADDR : state_q == POS ? POS_ADDR : '0;
      data = state_q == STATUS ? stat_sh_q : state_q == POS ? pos_sh_q : '0;
   end
   assign wen = wen_q;
   assign busy = busy_q;
   assign err = err_q;
endmodule

// File: tb/tb_mmio_state_writer.sv
// tb_mmio_state_writer: directed and randomized checks of mmio_state_writer against a word-queue model
module tb_mmio_state_writer;
   localparam logic [31:0] SA = 32'hFF00_0004;
   localparam logic [31:0] PA = 32'hFF00_0008;
   localparam int TMO = 8;
   logic clk = 1'b0, rst = 1'b1, update = 1'b0, ack = 1'b1;
   logic [2:0] gameState = '0;
   logic [1:0] p1State = '0, p2State = '0;
   logic [3:0] p1health = '0, p2health = '0;
   logic [7:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
   logic p1Left = 1'b0, p2Left = 1'b0;
   logic [31:0] addr, data;
   logic wen, busy, err;
   int total = 0, bad = 0;
   logic [32:0] mq[$];
   logic [31:0] ls, lp, s_save;
   int wt;
   bit mfirst, mpend, merr;

   mmio_state_writer #(.ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .update(update), .gameState(gameState),
      .p1State(p1State), .p2State(p2State), .p1health(p1health), .p2health(p2health),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .p1Left(p1Left), .p2Left(p2Left),
      .ack(ack), .addr(addr), .data(data), .wen(wen), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_stat();
      return (32'(gameState) << 28) + (32'(p1State) << 26) + (32'(p2State) << 24) +
             (32'(p1health) << 20) + (32'(p2health) << 16) + (32'(p1Left) << 1) + 32'(p2Left);
   endfunction

   function automatic logic [31:0] m_pos();
      return (32'(x1) << 24) + (32'(y1) << 16) + (32'(x2) << 8) + 32'(y2);
   endfunction

   task automatic m_build();
      logic [31:0] s, p;
      s = m_stat();
      p = m_pos();
      if (s != ls || mfirst) mq.push_back({1'b0, s});
      if (p != lp || mfirst) mq.push_back({1'b1, p});
      wt = 0;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            ls = '0; lp = '0; wt = 0;
            mfirst = 1'b1; mpend = 1'b0; merr = 1'b0;
         end else if (mq.size() == 0) begin
            if (update) m_build();
         end else begin
            mpend = mpend | update;
            if (ack) begin
               if (mq[0][32]) begin
                  lp = mq[0][31:0];
                  mfirst = 1'b0;
               end else ls = mq[0][31:0];
               void'(mq.pop_front());
               wt = 0;
            end else begin
               wt++;
               if (wt == TMO) begin
                  merr = 1'b1;
                  mq.delete();
                  wt = 0;
               end
            end
            if (mq.size() == 0 && mpend) begin
               mpend = 1'b0;
               m_build();
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("m_wen", 32'(wen), 32'(mq.size() != 0));
         chk("m_busy", 32'(busy), 32'(mq.size() != 0));
         chk("m_err", 32'(err), 32'(merr));
         chk("m_addr", addr, mq.size() == 0 ? 32'h0 : (mq[0][32] ? PA : SA));
         chk("m_data", data, mq.size() == 0 ? 32'h0 : mq[0][31:0]);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push();
      update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wen", 32'(wen), 0);
      chk("rst_addr", addr, 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      gameState = 3'd2; p1health = 4'd9; p2Left = 1'b1; x1 = 8'h40; ack = 1'b1;
      push();
      chk("t1_wen", 32'(wen), 1);
      chk("t1_saddr", addr, 32'hFF00_0004);
      chk("t1_sdata", data, 32'h2090_0001);
      tick();
      chk("t1_paddr", addr, 32'hFF00_0008);
      chk("t1_pdata", data, 32'h4000_0000);
      tick();
      chk("t1_idle", 32'(busy), 0);
      chk("t1_addr0", addr, 0);
      push();
      chk("t2_nowen", 32'(wen), 0);
      y2 = 8'h11;
      push();
      chk("t2_paddr", addr, PA);
      chk("t2_pdata", data, 32'h4000_0011);
      tick();
      chk("t2_idle", 32'(wen), 0);
      ack = 1'b0; p2health = 4'd3; x2 = 8'h22;
      push();
      chk("t3_sdata", data, 32'h2093_0001);
      s_save = data;
      repeat (3) begin
         tick();
         chk("t3_hold_addr", addr, SA);
         chk("t3_hold_data", data, s_save);
      end
      tick();
      ack = 1'b1;
      tick();
      chk("t3_paddr", addr, PA);
      chk("t3_pdata", data, 32'h4000_2211);
      tick();
      chk("t3_idle", 32'(busy), 0);
      ack = 1'b0; gameState = 3'd5;
      push();
      chk("t4_sdata", data, 32'h5093_0001);
      x1 = 8'h77; gameState = 3'd6;
      update = 1'b1; tick(); update = 1'b0; tick();
      update = 1'b1; tick(); update = 1'b0; tick();
      update = 1'b1; ack = 1'b1; tick(); update = 1'b0;
      chk("t4_rbusy", 32'(busy), 1);
      chk("t4_raddr", addr, SA);
      chk("t4_rdata", data, 32'h6093_0001);
      tick();
      chk("t4_paddr", addr, PA);
      chk("t4_pdata", data, 32'h7700_2211);
      tick();
      chk("t4_idle", 32'(busy), 0);
      tick();
      chk("t4_once", 32'(wen), 0);
      ack = 1'b0; p1State = 2'd2;
      push();
      chk("t5_sdata", data, 32'h6893_0001);
      repeat (7) tick();
      chk("t5_noerr", 32'(err), 0);
      chk("t5_wen8", 32'(wen), 1);
      tick();
      chk("t5_err", 32'(err), 1);
      chk("t5_wendrop", 32'(wen), 0);
      ack = 1'b1;
      push();
      chk("t5_retry_addr", addr, SA);
      chk("t5_retry_data", data, 32'h6893_0001);
      tick();
      chk("t5_idle", 32'(wen), 0);
      chk("t5_sticky", 32'(err), 1);
      ack = 1'b0; p2State = 2'd1;
      push();
      chk("t6_wen", 32'(wen), 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_wen0", 32'(wen), 0);
      chk("t6_addr0", addr, 0);
      chk("t6_data0", data, 0);
      chk("t6_busy0", 32'(busy), 0);
      chk("t6_err0", 32'(err), 0);
      #1 rst = 1'b0;
      tick();
      ack = 1'b1;
      push();
      chk("t6_sdata", data, 32'h6993_0001);
      tick();
      chk("t6_paddr", addr, PA);
      chk("t6_pdata", data, 32'h7700_2211);
      tick();
      chk("t6_idle", 32'(busy), 0);
      for (int i = 0; i < 3000; i++) begin
         update = $urandom_range(0, 3) == 0;
         ack = $urandom_range(0, 99) < ((i % 400) < 200 ? 70 : 15);
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
               0: gameState = 3'($urandom_range(0, 2));
               1: p1State = 2'($urandom_range(0, 3));
               2: p2health = 4'($urandom_range(0, 2));
               3: p1Left = 1'($urandom_range(0, 1));
               4: x1 = 8'($urandom_range(0, 2));
               5: y2 = 8'($urandom_range(250, 255));
               6: y1 = 8'($urandom);
               default: p2Left = 1'($urandom_range(0, 1));
            endcase
         end
         if ($urandom_range(0, 599) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end
      update = 1'b0;
      ack = 1'b1;
      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mmio_state_writer.md
# mmio_state_writer

Bus-master side of the game-state MMIO link: packs the game-logic state into the two fixed display words and writes them out as `addr`/`data` bus cycles. The display pipeline's MMIO decoder consumes these words. The block sits between the game-logic registers and the memory-bus arbiter. It snapshots state on an update strobe and writes only words that changed since the last committed write. It also coalesces updates that arrive while a write is in flight.

## Interface
Parameters:
- `STATUS_ADDR`, default 32'hFF000004: address of the status word.
- `POS_ADDR`, default 32'hFF000008: address of the position word.
- `ACK_TIMEOUT`, default 255: cycles to wait for `ack` before abandoning a word. 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `update` in 1: single-cycle strobe requesting a state push.
- `gameState` in 3: game state.
- `p1State`, `p2State` in 2 each: player states.
- `p1health`, `p2health` in 4 each: player health.
- `x1`, `y1`, `x2`, `y2` in 8 each: player positions.
- `p1Left`, `p2Left` in 1 each: facing direction.
- `ack` in 1: arbiter accepted the current write.
- `addr` out 32: write address. Equals 0 whenever no write is active.
- `data` out 32: write data. Equals 0 whenever no write is active.
- `wen` out 1: write request.
- `busy` out 1: FSM not in IDLE.
- `err` out 1: sticky flag, set by an ack timeout.

## Operation
Word packing (unused bits are 0):
- Status word: [30:28] gameState, [27:26] p1State, [25:24] p2State, [23:20] p1health, [19:16] p2health, [1] p1Left, [0] p2Left.
- Position word: [31:24] x1, [23:16] y1, [15:8] x2, [7:0] y2.

State machine, states IDLE, STATUS, POS:
- **IDLE.** When `update`=1, capture the packed status and position words into shadow registers, all fields in the same cycle.
  - If status shadow ≠ last-written status, or `first` is set: go to STATUS.
  - Otherwise, if position shadow ≠ last-written position: go to POS.
  - Otherwise stay in IDLE. Nothing is written.
- **STATUS.** Drive `wen`=1, `addr`=STATUS_ADDR, `data`=status shadow, held stable until exit.
  - On `ack`=1: last-written status ← shadow. Then go to POS if the position word differs or `first` is set; otherwise go to the exit check.
- **POS.** Same as STATUS, using POS_ADDR and the position shadow.
  - On `ack`=1: last-written position ← shadow, and clear `first`.
- **Exit check.**
  - If `pending`=1: re-snapshot the current inputs, clear `pending`, and apply the IDLE decision directly without passing through IDLE.
  - Otherwise go to IDLE.

Update handling:
- `update` while `busy` sets `pending`. Any number of such strobes coalesce into one re-push.
- `update` in the same cycle as the final `ack` also sets `pending`.

Timeout:
- A counter counts cycles spent in STATUS/POS without `ack`.
- When it reaches ACK_TIMEOUT (if nonzero): set `err`, leave last-written unchanged for that word (so the word is retried on the next update), and go to the exit check.
- The counter clears on every state entry.

Reset:
- Values: state IDLE; `addr`=0, `data`=0, `wen`=0, `busy`=0, `err`=0; shadows and last-written registers 0; `pending`=0; `first`=1.
- Reset asserted mid-write aborts the write immediately (asynchronously). No partial commit occurs.

## Timing
- `update` high at edge N → `wen`/`addr`/`data` valid in cycle N+1.
- `ack` is sampled at the rising edge. The word stays on the bus through the cycle in which `ack` is high.
- With `ack` tied high, a two-word push occupies exactly 2 cycles, and `busy` drops in cycle N+3.
- Input changes after the snapshot edge do not affect the words in flight.
- `busy` and `wen` are registered outputs. `addr`/`data` are decoded from registered state and shadows, with no input→output combinational path.

## Structure
- Shared package `t03_mmio_pkg` holds:
  - STATUS_ADDR and POS_ADDR localparams, shared with the decoder.
  - The `wstate_t` enum {IDLE, STATUS, POS}.
  - `pack_status` and `pack_pos` functions that define the bit layout once.
- No sub-module: the packing is handled by the package functions, and the FSM and counter are inline.

## Test plan
- Reset, then `update` with gameState=3'd2, p1health=4'd9, p2Left=1, x1=8'h40, `ack` tied 1 → cycle 1: addr=FF000004, data=32'h2090_0001. Cycle 2: addr=FF000008, data=32'h4000_0000. Cycle 3: idle.
- Repeat the identical `update` → no `wen` asserted. Change only y2 to 8'h11 → single POS write of 32'h4000_0011.
- Hold `ack`=0 for 4 cycles in STATUS → addr/data stay stable. Then `ack`=1 → POS follows on the next cycle.
- Three `update` strobes during a push, inputs changed after the first → exactly one follow-up push carrying the latest values, no return to IDLE in between.
- ACK_TIMEOUT=8, `ack`=0 → `err`=1 after 8 cycles, `wen` drops. The next `update` retries the same status word.
- Assert `rst` mid-STATUS → all outputs 0 in the same cycle. The next `update` writes both words (`first` is set again).
